// File: rtl/rr_mux8_1_if.sv
// Handshake bundle for the 8:1 round-robin collector.
// The slave modport is the collector's view; master is the source/sink side.
interface rr_mux8_1_if #(
    parameter int DATA_W = 4
);
    logic [7:0]             in_valid;
    logic [7:0][DATA_W-1:0] in_data;
    logic [7:0]             in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [2:0]             out_select;
    logic                   out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_select
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_select
    );
endinterface

// File: rtl/rr_mux8_1.sv
// Eight-lane round-robin collector: merges lanes into one registered stream
// tagged with the source lane index.

module rr_mux8_1_lane (
    input  logic req_hi,
    input  logic req_lo,
    input  logic below_hi,
    input  logic below_lo,
    input  logic any_hi,
    output logic gnt
);
    // Lanes at/after ptr take priority; otherwise the lowest valid lane wraps around.
    assign gnt = any_hi ? (req_hi & ~below_hi) : (req_lo & ~below_lo);
endmodule

module rr_mux8_1 #(
    parameter int DATA_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    rr_mux8_1_if.slave bus
);
    localparam int NUM_LANES = 8;

    logic [2:0]           ptr;
    logic                 load_en;
    logic [NUM_LANES-1:0] hi_mask;
    logic [NUM_LANES-1:0] req_hi;
    logic [NUM_LANES-1:0] req_lo;
    logic [NUM_LANES-1:0] below_hi;
    logic [NUM_LANES-1:0] below_lo;
    logic [NUM_LANES-1:0] gnt;
    logic                 any_hi;
    logic [2:0]           win;

    assign load_en = rst_n & (~bus.out_valid | bus.out_ready);

    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NUM_LANES; k++)
            hi_mask[k] = (3'(k) >= ptr);
    end

    assign req_lo = bus.in_valid;
    assign req_hi = bus.in_valid & hi_mask;
    assign any_hi = |req_hi;

    // Exclusive prefix-OR: is any lower-numbered lane requesting in each half.
    always_comb begin
        logic acc_hi;
        logic acc_lo;
        acc_hi   = 1'b0;
        acc_lo   = 1'b0;
        below_hi = '0;
        below_lo = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            below_hi[k] = acc_hi;
            below_lo[k] = acc_lo;
            acc_hi      = acc_hi | req_hi[k];
            acc_lo      = acc_lo | req_lo[k];
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        rr_mux8_1_lane u_lane (
            .req_hi   (req_hi[k]),
            .req_lo   (req_lo[k]),
            .below_hi (below_hi[k]),
            .below_lo (below_lo[k]),
            .any_hi   (any_hi),
            .gnt      (gnt[k])
        );
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < NUM_LANES; k++)
            if (gnt[k]) win = 3'(k);
    end

    assign bus.in_ready = gnt & {NUM_LANES{load_en}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_select <= '0;
            ptr            <= '0;
        end else if (load_en) begin
            if (|gnt) begin
                bus.out_valid  <= 1'b1;
                bus.out_data   <= bus.in_data[win];
                bus.out_select <= win;
                ptr            <= win + 3'd1;
            end else begin
                bus.out_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux8_1.sv
// Self-checking bench for rr_mux8_1: directed scenarios plus a randomized run
// against a scan-based round-robin reference model.
module tb_rr_mux8_1;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_mux8_1_if #(.DATA_W(DW)) bif ();

    rr_mux8_1 #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_ptr;
    bit            m_vld;
    logic [DW-1:0] m_data;
    logic [2:0]    m_sel;
    logic [7:0]    m_gnt;

    function automatic int m_win();
        for (int i = 0; i < 8; i++)
            if (bif.in_valid[(m_ptr + i) % 8]) return (m_ptr + i) % 8;
        return -1;
    endfunction

    function automatic logic [7:0] m_ready();
        logic [7:0] r;
        int w;
        r = 8'h00;
        w = m_win();
        if (rst_n && (!m_vld || bif.out_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        int w;
        bit ld;
        w     = m_win();
        ld    = rst_n && (!m_vld || bif.out_ready);
        m_gnt = m_ready();
        @(posedge clk);
        if (!rst_n) begin
            m_vld = 0; m_data = '0; m_sel = '0; m_ptr = 0;
        end else if (ld) begin
            if (w >= 0) begin
                m_vld  = 1;
                m_data = bif.in_data[w];
                m_sel  = 3'(w);
                m_ptr  = (w + 1) % 8;
            end else begin
                m_vld = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bif.in_valid  = 8'hFF;
        bif.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) bif.in_data[k] = DW'(k + 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bif.in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got=%h exp=00", bif.in_ready); end
            n_tests++;
            if (bif.out_valid !== 1'b0 || bif.out_data !== 4'h0 || bif.out_select !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0", bif.out_valid, bif.out_data, bif.out_select);
            end
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h01) begin n_fail++; $display("FAIL reset_first_grant got=%h exp=01", bif.in_ready); end
        bif.in_valid = 8'h00;
        #1;
        tick();
        n_tests++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle got v=%b exp 0", bif.out_valid); end
    endtask

    task automatic test_rotation();
        bif.in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if (bif.in_ready !== 8'(1 << (i % 8))) begin
                n_fail++; $display("FAIL rot_ready[%0d] got=%h exp=%h", i, bif.in_ready, 8'(1 << (i % 8)));
            end
            tick();
            n_tests++;
            if (bif.out_valid !== 1'b1 || bif.out_select !== 3'(i % 8) || bif.out_data !== DW'(i % 8 + 1)) begin
                n_fail++;
                $display("FAIL rot_out[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         i, bif.out_valid, bif.out_select, bif.out_data, i % 8, i % 8 + 1);
            end
        end
        bif.in_valid = 8'h00;
        tick();
    endtask

    task automatic test_single_lane();
        bif.in_valid   = 8'h20;
        bif.in_data[5] = 4'hA;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h20) begin n_fail++; $display("FAIL single_ready got=%h exp=20", bif.in_ready); end
        tick();
        bif.in_valid = 8'h00;
        #1;
        n_tests++;
        if (bif.out_valid !== 1'b1 || bif.out_select !== 3'd5 || bif.out_data !== 4'hA || bif.in_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL single_out got v=%b s=%0d d=%h r=%h exp v=1 s=5 d=a r=00",
                     bif.out_valid, bif.out_select, bif.out_data, bif.in_ready);
        end
        tick();
        n_tests++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got v=%b exp 0", bif.out_valid); end
    endtask

    task automatic test_pointer_wrap();
        bif.in_valid   = 8'h84;
        bif.in_data[2] = 4'h3;
        bif.in_data[7] = 4'hC;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h80) begin n_fail++; $display("FAIL wrap_ready7 got=%h exp=80", bif.in_ready); end
        tick();
        bif.in_valid[7] = 1'b0;
        #1;
        n_tests++;
        if (bif.out_select !== 3'd7 || bif.out_data !== 4'hC || bif.in_ready !== 8'h04) begin
            n_fail++;
            $display("FAIL wrap_out7 got s=%0d d=%h r=%h exp s=7 d=c r=04", bif.out_select, bif.out_data, bif.in_ready);
        end
        tick();
        bif.in_valid[2] = 1'b0;
        n_tests++;
        if (bif.out_valid !== 1'b1 || bif.out_select !== 3'd2 || bif.out_data !== 4'h3) begin
            n_fail++;
            $display("FAIL wrap_out2 got v=%b s=%0d d=%h exp v=1 s=2 d=3", bif.out_valid, bif.out_select, bif.out_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bif.in_valid   = 8'h28;
        bif.in_data[3] = 4'h4;
        bif.in_data[5] = 4'h6;
        bif.out_ready  = 1'b1;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h08) begin n_fail++; $display("FAIL bp_ready3 got=%h exp=08", bif.in_ready); end
        tick();
        bif.in_valid[3] = 1'b0;
        bif.out_ready   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (bif.in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got=%h exp=00", i, bif.in_ready); end
            tick();
            n_tests++;
            if (bif.out_valid !== 1'b1 || bif.out_select !== 3'd3 || bif.out_data !== 4'h4) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b s=%0d d=%h exp v=1 s=3 d=4", i, bif.out_valid, bif.out_select, bif.out_data);
            end
        end
        bif.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h20) begin n_fail++; $display("FAIL bp_drain_load got=%h exp=20", bif.in_ready); end
        tick();
        n_tests++;
        if (bif.out_valid !== 1'b1 || bif.out_select !== 3'd5 || bif.out_data !== 4'h6) begin
            n_fail++;
            $display("FAIL bp_next got v=%b s=%0d d=%h exp v=1 s=5 d=6", bif.out_valid, bif.out_select, bif.out_data);
        end
        bif.in_valid = 8'h00;
        tick();
    endtask

    task automatic test_mid_reset();
        bif.in_valid   = 8'h02;
        bif.in_data[1] = 4'h9;
        bif.out_ready  = 1'b0;
        #1;
        tick();
        bif.in_valid = 8'h00;
        n_tests++;
        if (bif.out_valid !== 1'b1 || bif.out_select !== 3'd1) begin
            n_fail++; $display("FAIL mr_held got v=%b s=%0d exp v=1 s=1", bif.out_valid, bif.out_select);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h00) begin n_fail++; $display("FAIL mr_ready got=%h exp=00", bif.in_ready); end
        tick();
        n_tests++;
        if (bif.out_valid !== 1'b0 || bif.out_select !== 3'd0 || bif.out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL mr_cleared got v=%b s=%0d d=%h exp v=0 s=0 d=0", bif.out_valid, bif.out_select, bif.out_data);
        end
        rst_n          = 1'b1;
        bif.out_ready  = 1'b1;
        bif.in_valid   = 8'h09;
        bif.in_data[0] = 4'h5;
        bif.in_data[3] = 4'h7;
        #1;
        n_tests++;
        if (bif.in_ready !== 8'h01) begin n_fail++; $display("FAIL mr_ptr0 got=%h exp=01", bif.in_ready); end
        tick();
        bif.in_valid[0] = 1'b0;
        n_tests++;
        if (bif.out_select !== 3'd0 || bif.out_data !== 4'h5) begin
            n_fail++; $display("FAIL mr_after got s=%0d d=%h exp s=0 d=5", bif.out_select, bif.out_data);
        end
        tick();
        bif.in_valid = 8'h00;
        n_tests++;
        if (bif.out_select !== 3'd3 || bif.out_data !== 4'h7) begin
            n_fail++; $display("FAIL mr_after2 got s=%0d d=%h exp s=3 d=7", bif.out_select, bif.out_data);
        end
        tick();
        n_tests++;
        if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_replay got v=%b exp 0", bif.out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bif.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++)
                if (!bif.in_valid[k] && $urandom_range(0, 2) == 0) begin
                    bif.in_valid[k] = 1'b1;
                    bif.in_data[k]  = DW'($urandom);
                end
            #1;
            n_tests++;
            if (bif.in_ready !== m_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d] got=%h exp=%h", c, bif.in_ready, m_ready());
            end
            tick();
            n_tests++;
            if (bif.out_valid !== m_vld || (m_vld && (bif.out_data !== m_data || bif.out_select !== m_sel))) begin
                n_fail++;
                $display("FAIL rand_out[%0d] got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                         c, bif.out_valid, bif.out_select, bif.out_data, m_vld, m_sel, m_data);
            end
            bif.in_valid = bif.in_valid & ~m_gnt;
        end
        bif.in_valid  = 8'h00;
        bif.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_lane();
        test_pointer_wrap();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
